// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch unit: default widths, the fetch FSM
// state encoding and the queue entry layout handed to decode.
package fetch_pkg;

    localparam int PC_W_DEF   = 10;
    localparam int INST_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Two-entry FIFO between fetch and decode. Slot 0 is always the head.
// A flush empties the queue and overrides any push in the same cycle.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         do_pop;
    logic         do_push;

    // Qualify requests so the queue never underflows or overflows.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
        head    = slot0;
    end

    // Storage and occupancy update; flush and reset clear everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the ROM address, and queues
// {PC, instruction} pairs for decode behind a valid/ready handshake.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              INST_W     = INST_W_DEF,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Halt,
    input  logic              Redirect,
    input  logic [PC_W-1:0]   RedirectTarget,
    output logic [PC_W-1:0]   InstAddress,
    input  logic [INST_W-1:0] InstIn,
    output logic              InstValid,
    output logic [INST_W-1:0] InstData,
    output logic [PC_W-1:0]   InstPC,
    input  logic              InstReady,
    output logic              Running,
    output logic              Wrapped
);

    fetch_state_t state;
    logic [PC_W-1:0] pc;
    logic [1:0]      q_count;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic            in_run;
    logic            halt_now;
    logic            redirect_now;
    logic            start_now;
    logic            q_push;
    logic            q_pop;
    logic            q_flush;

    // Control decode: a Halt/Redirect cycle voids any handshake with decode.
    always_comb begin
        in_run       = (state == RUN);
        halt_now     = in_run && Halt;
        redirect_now = in_run && !Halt && Redirect;
        start_now    = !in_run && Start;
        q_pop        = InstValid && InstReady && !Halt && !Redirect;
        q_push       = in_run && !Halt && !Redirect && ((q_count != 2'd2) || q_pop);
        q_flush      = halt_now || redirect_now || start_now;
        push_entry   = '{pc: pc, inst: InstIn};
        InstAddress  = pc;
        InstValid    = (q_count != 2'd0);
        InstData     = head.inst;
        InstPC       = head.pc;
    end

    // Fetch FSM with PC register, running flag and sticky wrap flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            pc      <= START_ADDR;
            Running <= 1'b0;
            Wrapped <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (Start) begin
                        state   <= RUN;
                        Running <= 1'b1;
                        pc      <= START_ADDR;
                        Wrapped <= 1'b0;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state   <= HALTED;
                        Running <= 1'b0;
                    end else if (Redirect) begin
                        pc <= RedirectTarget;
                    end else if (q_push) begin
                        pc <= pc + 1'b1;
                        if (pc == '1) begin
                            Wrapped <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue u_queue (
        .clk   (Clk),
        .rst   (Reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (push_entry),
        .head  (head),
        .count (q_count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a random phase,
// all compared against a queue-based behavioural model of the fetch unit.
module tb_inst_fetch;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       redirect = 1'b0;
    logic [9:0] target = '0;
    logic       ready = 1'b0;
    logic       sel = 1'b0;

    logic [9:0] a0, a1, pc0, pc1;
    logic [8:0] d0, d1;
    logic       v0, v1, r0, r1, w0, w1;

    logic [9:0] obs_addr, obs_pc;
    logic [8:0] obs_data;
    logic       obs_valid, obs_running, obs_wrapped;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 Clk = ~Clk;

    inst_fetch dut0 (
        .Clk(Clk), .Reset(reset),
        .Start(start && !sel), .Halt(halt && !sel), .Redirect(redirect && !sel),
        .RedirectTarget(target), .InstAddress(a0), .InstIn(a0[8:0]),
        .InstValid(v0), .InstData(d0), .InstPC(pc0), .InstReady(ready && !sel),
        .Running(r0), .Wrapped(w0)
    );

    inst_fetch #(.START_ADDR(10'd1022)) dut1 (
        .Clk(Clk), .Reset(reset),
        .Start(start && sel), .Halt(halt && sel), .Redirect(redirect && sel),
        .RedirectTarget(target), .InstAddress(a1), .InstIn(a1[8:0]),
        .InstValid(v1), .InstData(d1), .InstPC(pc1), .InstReady(ready && sel),
        .Running(r1), .Wrapped(w1)
    );

    assign obs_addr    = sel ? a1 : a0;
    assign obs_pc      = sel ? pc1 : pc0;
    assign obs_data    = sel ? d1 : d0;
    assign obs_valid   = sel ? v1 : v0;
    assign obs_running = sel ? r1 : r0;
    assign obs_wrapped = sel ? w1 : w0;

    // Behavioural model: state as a small integer, queue as an SV queue.
    localparam int unsigned M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    typedef struct { int unsigned pc; int unsigned inst; } ent_t;
    ent_t        mq[$];
    int unsigned m_state = M_IDLE;
    int unsigned m_pc = 0;
    bit          m_wrap = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("addr", {22'd0, obs_addr}, m_pc);
        chk("running", {31'd0, obs_running}, {31'd0, m_state == M_RUN});
        chk("wrapped", {31'd0, obs_wrapped}, {31'd0, m_wrap});
        chk("valid", {31'd0, obs_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("head_pc", {22'd0, obs_pc}, mq[0].pc);
            chk("head_data", {23'd0, obs_data}, mq[0].inst);
        end
    endtask

    // Advance model and DUT by one clock, then compare.
    task automatic step();
        int unsigned sa = sel ? 1022 : 0;
        ent_t e;
        bit popok;
        if (reset) begin
            m_state = M_IDLE; m_pc = sa; m_wrap = 1'b0; mq.delete();
        end else if (m_state != M_RUN) begin
            if (start) begin
                m_state = M_RUN; m_pc = sa; m_wrap = 1'b0; mq.delete();
            end
        end else begin
            popok = (mq.size() != 0) && ready && !halt && !redirect;
            if (halt) begin
                m_state = M_HALT; mq.delete();
            end else if (redirect) begin
                m_pc = target; mq.delete();
            end else begin
                if (popok) void'(mq.pop_front());
                if (mq.size() < 2) begin
                    e.pc = m_pc; e.inst = m_pc % 512;
                    mq.push_back(e);
                    m_pc = (m_pc + 1) % 1024;
                    if (m_pc == 0) m_wrap = 1'b1;
                end
            end
        end
        @(posedge Clk);
        #1;
        check_all();
    endtask

    int unsigned saved_pc;

    initial begin
        // Power-up reset
        step(); step();
        chk("rst_data", {23'd0, obs_data}, 32'd0);
        chk("rst_pc", {22'd0, obs_pc}, 32'd0);
        reset = 1'b0;

        // Start and stream with ready high
        ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        chk("start_addr", {22'd0, obs_addr}, 32'd0);
        step();
        chk("first_pc", {22'd0, obs_pc}, 32'd0);
        step();
        chk("second_pc", {22'd0, obs_pc}, 32'd1);
        step();
        chk("third_pc", {22'd0, obs_pc}, 32'd2);
        repeat (4) step();

        // Restart with backpressure
        halt = 1'b1; step(); halt = 1'b0;
        ready = 1'b0; start = 1'b1; step(); start = 1'b0;
        step();
        repeat (5) step();
        chk("stall_head", {22'd0, obs_pc}, 32'd0);
        chk("stall_addr", {22'd0, obs_addr}, 32'd2);
        ready = 1'b1;
        step(); chk("release1", {22'd0, obs_pc}, 32'd1);
        step(); chk("release2", {22'd0, obs_pc}, 32'd2);
        step(); chk("release3", {22'd0, obs_pc}, 32'd3);

        // Redirect with a full queue; same-cycle handshake discarded
        ready = 1'b0; repeat (3) step();
        redirect = 1'b1; target = 10'h200; ready = 1'b1; step();
        redirect = 1'b0;
        chk("redir_valid", {31'd0, obs_valid}, 32'd0);
        chk("redir_addr", {22'd0, obs_addr}, 32'h200);
        step();
        chk("redir_head", {22'd0, obs_pc}, 32'h200);
        repeat (3) step();

        // Halt together with Redirect
        saved_pc = m_pc;
        halt = 1'b1; redirect = 1'b1; target = 10'h100; step();
        halt = 1'b0; redirect = 1'b0;
        chk("halt_running", {31'd0, obs_running}, 32'd0);
        chk("halt_addr", {22'd0, obs_addr}, saved_pc);
        repeat (2) step();
        start = 1'b1; step(); start = 1'b0;
        chk("resume_addr", {22'd0, obs_addr}, 32'd0);
        repeat (3) step();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(99) < 1);
            start    = ($urandom_range(99) < 6);
            halt     = ($urandom_range(99) < 3);
            redirect = ($urandom_range(99) < 5);
            ready    = ($urandom_range(99) < 70);
            target   = 10'($urandom);
            step();
        end
        reset = 1'b0; start = 1'b0; halt = 1'b0; redirect = 1'b0;

        // Reset while running with a full queue
        halt = 1'b1; step(); halt = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        ready = 1'b0; repeat (3) step();
        chk("full_valid", {31'd0, obs_valid}, 32'd1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_valid", {31'd0, obs_valid}, 32'd0);
        chk("mid_rst_running", {31'd0, obs_running}, 32'd0);
        chk("mid_rst_data", {23'd0, obs_data}, 32'd0);
        chk("mid_rst_pc", {22'd0, obs_pc}, 32'd0);
        chk("mid_rst_addr", {22'd0, obs_addr}, 32'd0);
        ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        step();
        chk("post_rst_head", {22'd0, obs_pc}, 32'd0);
        step();

        // Wrap behaviour on the START_ADDR=1022 instance
        sel = 1'b1; reset = 1'b1; step(); reset = 1'b0;
        ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        step();
        chk("wrap_head0", {22'd0, obs_pc}, 32'd1022);
        step();
        chk("wrap_head1", {22'd0, obs_pc}, 32'd1023);
        chk("wrap_set", {31'd0, obs_wrapped}, 32'd1);
        step();
        chk("wrap_head2", {22'd0, obs_pc}, 32'd0);
        halt = 1'b1; step(); halt = 1'b0;
        chk("wrap_sticky", {31'd0, obs_wrapped}, 32'd1);
        start = 1'b1; step(); start = 1'b0;
        chk("wrap_clear", {31'd0, obs_wrapped}, 32'd0);
        chk("restart_addr", {22'd0, obs_addr}, 32'd1022);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the address-driving end of the instruction ROM interface. It owns the program counter, presents it as a 10-bit address to the combinational instruction ROM, captures the 9-bit word returned in the same cycle and hands {PC, instruction} to decode through a 2-entry queue with a valid/ready handshake. It sits between the instruction ROM and the decode stage, and accepts start, halt and branch-redirect control from decode.

## Interface
- PC_W, 10, program-counter and ROM address width
- INST_W, 9, instruction width
- START_ADDR, 0, PC loaded on Start
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  pulse; begin fetching from START_ADDR
- Halt  in  1  stop fetching and flush queue
- Redirect  in  1  branch taken; flush queue and reload PC
- RedirectTarget  in  PC_W  new PC when Redirect=1
- InstAddress  out  PC_W  ROM address (= PC register)
- InstIn  in  INST_W  ROM data, valid combinationally in the same cycle
- InstValid  out  1  queue head valid
- InstData  out  INST_W  head instruction
- InstPC  out  PC_W  head instruction's address
- InstReady  in  1  decode accepts head
- Running  out  1  state == RUN
- Wrapped  out  1  sticky: PC wrapped from 2^PC_W-1 to 0

## Operation
- States: IDLE (reset), RUN, HALTED.
- IDLE/HALTED + Start -> RUN; PC <= START_ADDR; Wrapped <= 0; queue flushed.
- RUN + Halt -> HALTED; queue flushed; PC holds.
- RUN + Redirect (Halt=0) -> PC <= RedirectTarget; queue flushed; no push this cycle.
- Priority in RUN: Halt > Redirect > normal fetch. Start ignored in RUN. Redirect and Halt ignored in IDLE/HALTED.
- Pop: InstValid && InstReady, except when Halt or Redirect is asserted in the same cycle. In that case the handshake is void and the entry is discarded.
- Push: RUN, no Halt/Redirect, and (count < 2 or pop this cycle). Pushes {PC, InstIn} and sets PC <= PC+1.
- Simultaneous push and pop with count == 2: both occur; count stays 2.
- PC arithmetic is modulo 2^PC_W. Increment from 1023 gives 0 and sets Wrapped. Wrapped is cleared only by Reset or Start.
- Queue FIFO order is strict. InstData/InstPC hold their value while InstValid=1 and InstReady=0.
- Reset: state IDLE, PC = START_ADDR, count 0. InstValid, Running, Wrapped, InstData and InstPC are all 0.
- Reset mid-operation: all of the above on the next edge. Queue contents are dropped.

## Timing
- All outputs are registered except InstAddress, which is the PC register itself.
- Start at cycle t: Running=1 and InstAddress=START_ADDR at t+1; first push at end of t+1; InstValid=1 at t+2.
- Redirect at t: InstValid=0 and InstAddress=target at t+1; target instruction valid at t+2.
- Halt at t: Running=0 and InstValid=0 at t+1.
- Steady state with InstReady held high: one instruction per cycle, no bubbles.
- Backpressure: queue fills in 2 cycles, then PC stalls. Restart on InstReady costs no bubble.

## Structure
- Package fetch_pkg: PC_W/INST_W defaults, fetch_state_t enum {IDLE, RUN, HALTED}, and the fetch_entry_t struct {pc, inst}.
- Sub-module fetch_queue: 2-entry FIFO of fetch_entry_t with push, pop and flush inputs and count/head outputs; flush wins over push.
- Top level contains the FSM, PC register and wrap flag.

## Test plan
- Reset, then Start with ROM[i]=i: (InstPC, InstData) = (0,0), (1,1), (2,2) … on consecutive cycles from t+2 with InstReady=1.
- InstReady low 5 cycles after first valid: head holds (0,0); InstAddress stalls at 2. Release InstReady: 1, 2, 3 follow with no bubble.
- Redirect to 0x200 while queue holds 2 entries: next cycle InstValid=0; the following cycle InstPC=0x200; the same-cycle handshake is discarded.
- Halt together with Redirect: HALTED, InstValid=0, PC unchanged. A later Start resumes at START_ADDR.
- Start with START_ADDR=1022: InstPC 1022, 1023, 0; Wrapped=1 after the 1023 push; the next Start clears Wrapped.
- Reset asserted while RUN with a full queue: next cycle all outputs 0 and state IDLE; Start behaves as from power-up.
